// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the iterative decrypt core.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    ADDK  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Block-in / block-out valid-ready bus of the iterative AES-128 decrypt core.
interface aes_decrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  modport master (
    output in_valid, ciphertext, key, out_ready,
    input  in_ready, out_valid, plaintext
  );

  modport slave (
    input  in_valid, ciphertext, key, out_ready,
    output in_ready, out_valid, plaintext
  );
endinterface

// File: rtl/aes_inv_round.sv
// One AES inverse round plus one inverse key-schedule step, purely combinational.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk_in,
  input  logic [3:0]   rc,
  input  logic         last,
  output logic [127:0] st_next,
  output logic [127:0] rk_prev
);

  logic [127:0] sb_s;
  logic [127:0] t_s;
  logic [127:0] mc_s;

  assign rk_prev = inv_expand_key(rk_in, rcon(rc));

  // InvShiftRows fused with InvSubBytes: row r of column c comes from column c-r.
  always_comb begin
    sb_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb_s[127-8*(4*c+r) -: 8] = inv_sbox(st[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
  end

  assign t_s = sb_s ^ rk_prev;

  // InvMixColumns on each 32-bit column.
  always_comb begin
    mc_s = '0;
    for (int c = 0; c < 4; c++) begin
      mc_s[127-32*c -: 8] = gmul(t_s[127-32*c -: 8], 8'h0e) ^ gmul(t_s[119-32*c -: 8], 8'h0b)
                          ^ gmul(t_s[111-32*c -: 8], 8'h0d) ^ gmul(t_s[103-32*c -: 8], 8'h09);
      mc_s[119-32*c -: 8] = gmul(t_s[127-32*c -: 8], 8'h09) ^ gmul(t_s[119-32*c -: 8], 8'h0e)
                          ^ gmul(t_s[111-32*c -: 8], 8'h0b) ^ gmul(t_s[103-32*c -: 8], 8'h0d);
      mc_s[111-32*c -: 8] = gmul(t_s[127-32*c -: 8], 8'h0d) ^ gmul(t_s[119-32*c -: 8], 8'h09)
                          ^ gmul(t_s[111-32*c -: 8], 8'h0e) ^ gmul(t_s[103-32*c -: 8], 8'h0b);
      mc_s[103-32*c -: 8] = gmul(t_s[127-32*c -: 8], 8'h0b) ^ gmul(t_s[119-32*c -: 8], 8'h0d)
                          ^ gmul(t_s[111-32*c -: 8], 8'h09) ^ gmul(t_s[103-32*c -: 8], 8'h0e);
    end
  end

  assign st_next = last ? t_s : mc_s;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption, one round per clock with on-the-fly key schedule.
// Optional AES_DEC_KEY_CACHE_EN keeps the last key and its K10 to skip forward expansion.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
)(
  input logic               clk,
  input logic               rst_n,
  aes_decrypt_iter_if.slave bus
);

  state_t       state_r;
  logic [127:0] st_r;
  logic [127:0] rk_r;
  logic [3:0]   rc_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic [127:0] pt_r;

  logic [127:0] rk_fwd_s;
  logic [127:0] st_nxt_s;
  logic [127:0] rk_prv_s;
  logic         last_s;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key_r;
  logic [127:0] cache_k10_r;
  logic         cache_vld_r;
`endif

  assign rk_fwd_s = expand_key(rk_r, rcon(rc_r));
  assign last_s   = (rc_r == 4'd1);

  aes_inv_round u_inv_round (
    .st      (st_r),
    .rk_in   (rk_r),
    .rc      (rc_r),
    .last    (last_s),
    .st_next (st_nxt_s),
    .rk_prev (rk_prv_s)
  );

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      st_r        <= '0;
      rk_r        <= '0;
      rc_r        <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      pt_r        <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key_r <= '0;
      cache_k10_r <= '0;
      cache_vld_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            st_r       <= bus.ciphertext;
            rc_r       <= 4'd1;
            in_ready_r <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_vld_r && (bus.key == cache_key_r)) begin
              rk_r    <= cache_k10_r;
              state_r <= ADDK;
            end else begin
              rk_r        <= bus.key;
              cache_key_r <= bus.key;
              cache_vld_r <= 1'b0;
              state_r     <= KEXP;
            end
`else
            rk_r    <= bus.key;
            state_r <= KEXP;
`endif
          end
        end
        KEXP: begin
          rk_r <= rk_fwd_s;
          rc_r <= rc_r + 4'd1;
          if (rc_r == 4'(NR)) begin
            state_r <= ADDK;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_k10_r <= rk_fwd_s;
            cache_vld_r <= 1'b1;
`endif
          end
        end
        ADDK: begin
          st_r    <= st_r ^ rk_r;
          rc_r    <= 4'(NR);
          state_r <= ROUND;
        end
        ROUND: begin
          st_r <= st_nxt_s;
          rk_r <= rk_prv_s;
          rc_r <= rc_r - 4'd1;
          if (last_s) begin
            pt_r        <= st_nxt_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.plaintext = pt_r;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed FIPS-197 vector bench for aes_decrypt_iter (default or AES_DEC_KEY_CACHE_EN build).
module tb_aes_decrypt_iter;

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_decrypt_iter_if bus ();

  aes_decrypt_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int exp_lat  = 21;

  logic         m_vld = 1'b0;
  logic [127:0] m_key = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [127:0] ct, input logic [127:0] k);
    @(negedge clk);
    for (int i = 0; i < 100 && !bus.in_ready; i++) @(negedge clk);
    check_val("accept_ready", 128'(bus.in_ready), 128'd1);
    bus.in_valid   = 1'b1;
    bus.ciphertext = ct;
    bus.key        = k;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
`ifdef AES_DEC_KEY_CACHE_EN
    exp_lat = (m_vld && (k == m_key)) ? 11 : 21;
    m_vld   = 1'b1;
    m_key   = k;
`else
    exp_lat = 21;
`endif
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.ciphertext = ~ct;
    bus.key        = ~k;
  endtask

  task automatic wait_out(input string tag, input logic [127:0] exp_pt);
    for (int i = 0; i < 100 && !bus.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check_val({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
    check_val({tag, "_pt"}, bus.plaintext, exp_pt);
    check_val({tag, "_lat"}, 128'(cyc - acc_cyc), 128'(exp_lat));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val({tag, "_rel_valid"}, 128'(bus.out_valid), 128'd0);
    check_val({tag, "_rel_ready"}, 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.ciphertext = '0;
    bus.key        = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check_val("rst_plaintext", bus.plaintext, 128'd0);
    check_val("rst_in_ready", 128'(bus.in_ready), 128'd1);

    accept(C1_CT, C1_KEY);
    wait_out("c1", C1_PT);
    release_out("c1");

    accept(B_CT, B_KEY);
    wait_out("b", B_PT);
    release_out("b");

    // Backpressure: hold the result while a competing block is offered.
    accept(C1_CT, C1_KEY);
    wait_out("bp", C1_PT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.ciphertext = B_CT;
      bus.key        = B_KEY;
      @(posedge clk);
      #1;
      check_val("bp_hold_valid", 128'(bus.out_valid), 128'd1);
      check_val("bp_hold_pt", bus.plaintext, C1_PT);
      check_val("bp_hold_ready", 128'(bus.in_ready), 128'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    release_out("bp");

    // Busy input: a second block pulsed mid-operation must be dropped.
    accept(B_CT, B_KEY);
    repeat (4) @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.ciphertext = C1_CT;
    bus.key        = C1_KEY;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out("busy", B_PT);
    release_out("busy");
    repeat (30) @(posedge clk);
    #1;
    check_val("busy_no_second", 128'(bus.out_valid), 128'd0);
    check_val("busy_idle_ready", 128'(bus.in_ready), 128'd1);

    // Reset in the 8th KEXP cycle aborts the block.
    accept(C1_CT, C1_KEY);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_vld = 1'b0;
    #1;
    check_val("mid_rst_valid", 128'(bus.out_valid), 128'd0);
    check_val("mid_rst_pt", bus.plaintext, 128'd0);
    check_val("mid_rst_ready", 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    accept(C1_CT, C1_KEY);
    wait_out("post_rst", C1_PT);
    release_out("post_rst");

    // Same key again (cache hit when enabled), then a different key.
    accept(C1_CT, C1_KEY);
    wait_out("repeat_key", C1_PT);
    release_out("repeat_key");
    accept(B_CT, B_KEY);
    wait_out("new_key", B_PT);
    release_out("new_key");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
